// File: rtl/lc3_exec_pkg.sv
// Shared types, e_cntrl field positions and sign-extension helper for the LC3 Execute stage.
// Rev 1.0
`default_nettype none

package lc3_exec_pkg;

  localparam int LC3_W = 16;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_LD  = 4'b0010,
    OP_ST  = 4'b0011,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_LDI = 4'b1010,
    OP_STI = 4'b1011,
    OP_JMP = 4'b1100,
    OP_LEA = 4'b1110
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    PC1_OFF11 = 2'b00,
    PC1_OFF9  = 2'b01,
    PC1_OFF6  = 2'b10,
    PC1_ZERO  = 2'b11
  } pcsel1_e;

  localparam int EC_ALU_HI = 5;
  localparam int EC_ALU_LO = 4;
  localparam int EC_PC1_HI = 3;
  localparam int EC_PC1_LO = 2;
  localparam int EC_PCSEL2 = 1;
  localparam int EC_OP2SEL = 0;

  // Sign-extend the low n bits of v to the full datapath width.
  function automatic logic [LC3_W-1:0] sext(input logic [15:0] v, input int n);
    logic [LC3_W-1:0] r;
    for (int i = 0; i < LC3_W; i++) begin
      r[i] = (i < n) ? v[i] : v[n-1];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lc3_exec_alu.sv
// Combinational LC3 ALU: ADD, AND, NOT of operand 1, or pass-through of operand 2.
// Rev 1.0
`default_nettype none

module lc3_exec_alu
  import lc3_exec_pkg::*;
#(
  parameter int DATA_W = LC3_W
) (
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  alu_ctrl_e         i_alu_ctrl,
  output logic [DATA_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_alu_ctrl)
      ALU_ADD:  o_result = i_op1 + i_op2;
      ALU_AND:  o_result = i_op1 & i_op2;
      ALU_NOT:  o_result = ~i_op1;
      ALU_PASS: o_result = i_op2;
      default:  o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lc3_execute.sv
// LC3 Execute stage: operand bypass, ALU and address generation, registered results for Memory/Writeback.
// Rev 1.0
`default_nettype none

module lc3_execute
  import lc3_exec_pkg::*;
#(
  parameter int DATA_W = LC3_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic [5:0]        e_cntrl,
  input  logic              m_cntrl_in,
  input  logic [1:0]        w_cntrl_in,
  input  logic [15:0]       Instr_Reg,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
  input  logic              bypass_mem_1,
  input  logic              bypass_mem_2,
  input  logic [DATA_W-1:0] Mem_Bypass_Val,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [DATA_W-1:0] M_Data,
  output logic [2:0]        dr,
  output logic [15:0]       IR_Exec,
  output logic [2:0]        NZP,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out
);

  opcode_e           w_opcode;
  alu_ctrl_e         w_alu_ctrl;
  pcsel1_e           w_pcsel1;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_offset;
  logic [DATA_W-1:0] w_base;
  logic [DATA_W-1:0] w_addr;
  logic [2:0]        w_nzp;

  assign w_opcode   = opcode_e'(Instr_Reg[15:12]);
  assign w_alu_ctrl = alu_ctrl_e'(e_cntrl[EC_ALU_HI:EC_ALU_LO]);
  assign w_pcsel1   = pcsel1_e'(e_cntrl[EC_PC1_HI:EC_PC1_LO]);

  // Stores read the data register through the sr2 port.
  assign sr1 = Instr_Reg[8:6];
  always_comb begin
    sr2 = Instr_Reg[2:0];
    case (w_opcode)
      OP_ST, OP_STR, OP_STI: sr2 = Instr_Reg[11:9];
      default:               sr2 = Instr_Reg[2:0];
    endcase
  end

  // aluout holds the previous instruction's result, so the ALU bypass takes priority.
  assign w_op1 = bypass_alu_1 ? aluout : (bypass_mem_1 ? Mem_Bypass_Val : VSR1);
  assign w_op2 = bypass_alu_2 ? aluout : (bypass_mem_2 ? Mem_Bypass_Val : VSR2);

  assign w_alu_b = e_cntrl[EC_OP2SEL] ? w_op2 : sext(Instr_Reg, 5);

  lc3_exec_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op1      (w_op1),
    .i_op2      (w_alu_b),
    .i_alu_ctrl (w_alu_ctrl),
    .o_result   (w_alu_res)
  );

  always_comb begin
    w_offset = '0;
    case (w_pcsel1)
      PC1_OFF11: w_offset = sext(Instr_Reg, 11);
      PC1_OFF9:  w_offset = sext(Instr_Reg, 9);
      PC1_OFF6:  w_offset = sext(Instr_Reg, 6);
      PC1_ZERO:  w_offset = '0;
      default:   w_offset = '0;
    endcase
  end

  assign w_base = e_cntrl[EC_PCSEL2] ? npc_in : w_op1;
  assign w_addr = w_base + w_offset;

  always_comb begin
    w_nzp = 3'b000;
    case (w_opcode)
      OP_BR:   w_nzp = Instr_Reg[11:9];
      OP_JMP:  w_nzp = 3'b111;
      default: w_nzp = 3'b000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluout          <= '0;
      pcout           <= '0;
      M_Data          <= '0;
      dr              <= '0;
      IR_Exec         <= '0;
      NZP             <= '0;
      W_Control_out   <= '0;
      Mem_Control_out <= 1'b0;
    end else if (enable_execute) begin
      aluout          <= (w_opcode == OP_LEA) ? w_addr : w_alu_res;
      pcout           <= w_addr;
      M_Data          <= w_op2;
      dr              <= Instr_Reg[11:9];
      IR_Exec         <= Instr_Reg;
      NZP             <= w_nzp;
      W_Control_out   <= w_cntrl_in;
      Mem_Control_out <= m_cntrl_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3_execute.sv
// Self-checking bench for lc3_execute: directed scenarios plus randomized traffic against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_lc3_execute;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [5:0]  e_cntrl;
  logic        m_cntrl_in;
  logic [1:0]  w_cntrl_in;
  logic [15:0] Instr_Reg, npc_in, VSR1, VSR2, Mem_Bypass_Val;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;

  int checks = 0;
  int errors = 0;

  // Model state: what each registered output should currently hold.
  logic [15:0] e_alu, e_pc, e_md, e_ir;
  logic [2:0]  e_dr, e_nzp;
  logic [1:0]  e_w;
  logic        e_m;

  lc3_execute dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute),
    .e_cntrl(e_cntrl), .m_cntrl_in(m_cntrl_in), .w_cntrl_in(w_cntrl_in),
    .Instr_Reg(Instr_Reg), .npc_in(npc_in), .VSR1(VSR1), .VSR2(VSR2),
    .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
    .Mem_Bypass_Val(Mem_Bypass_Val), .sr1(sr1), .sr2(sr2),
    .aluout(aluout), .pcout(pcout), .M_Data(M_Data), .dr(dr),
    .IR_Exec(IR_Exec), .NZP(NZP), .W_Control_out(W_Control_out),
    .Mem_Control_out(Mem_Control_out)
  );

  always #5 clock = ~clock;

  function automatic int sx(int v, int n);
    int f;
    f = v % (1 << n);
    if (f >= (1 << (n - 1))) return f - (1 << n);
    return f;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    e_alu = 0; e_pc = 0; e_md = 0; e_ir = 0;
    e_dr = 0; e_nzp = 0; e_w = 0; e_m = 0;
  endtask

  task automatic model_clock();
    int ir, opc, op1, op2, b, res, off, base, addr;
    if (reset) begin
      model_zero();
    end else if (enable_execute) begin
      ir  = int'(Instr_Reg);
      opc = ir / 4096;
      op1 = bypass_alu_1 ? int'(e_alu) : (bypass_mem_1 ? int'(Mem_Bypass_Val) : int'(VSR1));
      op2 = bypass_alu_2 ? int'(e_alu) : (bypass_mem_2 ? int'(Mem_Bypass_Val) : int'(VSR2));
      b   = e_cntrl[0] ? op2 : (sx(ir, 5) & 16'hFFFF);
      case (e_cntrl[5:4])
        2'd0:    res = op1 + b;
        2'd1:    res = op1 & b;
        2'd2:    res = 16'hFFFF - op1;
        default: res = b;
      endcase
      case (e_cntrl[3:2])
        2'd0:    off = sx(ir, 11);
        2'd1:    off = sx(ir, 9);
        2'd2:    off = sx(ir, 6);
        default: off = 0;
      endcase
      base  = e_cntrl[1] ? int'(npc_in) : op1;
      addr  = (base + off) & 16'hFFFF;
      e_alu = (opc == 14) ? 16'(addr) : 16'(res & 16'hFFFF);
      e_pc  = 16'(addr);
      e_md  = 16'(op2);
      e_dr  = 3'((ir / 512) % 8);
      e_ir  = Instr_Reg;
      e_nzp = (opc == 0) ? 3'((ir / 512) % 8) : ((opc == 12) ? 3'd7 : 3'd0);
      e_w   = w_cntrl_in;
      e_m   = m_cntrl_in;
    end
  endtask

  task automatic chk_src();
    int ir, opc;
    ir  = int'(Instr_Reg);
    opc = ir / 4096;
    chk("sr1", 16'(sr1), 16'((ir / 64) % 8));
    chk("sr2", 16'(sr2), (opc == 3 || opc == 7 || opc == 11) ? 16'((ir / 512) % 8) : 16'(ir % 8));
  endtask

  task automatic chk_regs();
    chk("aluout", aluout, e_alu);
    chk("pcout", pcout, e_pc);
    chk("M_Data", M_Data, e_md);
    chk("dr", 16'(dr), 16'(e_dr));
    chk("IR_Exec", IR_Exec, e_ir);
    chk("NZP", 16'(NZP), 16'(e_nzp));
    chk("W_Control_out", 16'(W_Control_out), 16'(e_w));
    chk("Mem_Control_out", 16'(Mem_Control_out), 16'(e_m));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_clock();
    #1;
    chk_regs();
  endtask

  task automatic drive(logic [15:0] ir, logic [5:0] ec, logic [15:0] v1, logic [15:0] v2,
                       logic [15:0] npc, logic [3:0] byp, logic [15:0] mbv);
    Instr_Reg = ir; e_cntrl = ec; VSR1 = v1; VSR2 = v2; npc_in = npc;
    {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
    Mem_Bypass_Val = mbv;
  endtask

  initial begin
    reset = 1'b1; enable_execute = 1'b1; m_cntrl_in = 1'b0; w_cntrl_in = 2'b00;
    drive(16'h0000, 6'b0, 16'h0, 16'h0, 16'h0, 4'b0, 16'h0);
    model_zero();
    #2;
    chk_regs();
    #5 reset = 1'b0;
    #1;

    // ADD R1,R2,R3
    drive(16'h1283, 6'b000001, 16'h0005, 16'h0007, 16'h3000, 4'b0, 16'h0);
    m_cntrl_in = 1'b1; w_cntrl_in = 2'b10;
    #1;
    chk("add_sr1", 16'(sr1), 16'd2);
    chk("add_sr2", 16'(sr2), 16'd3);
    chk_src();
    cycle();
    chk("add_aluout", aluout, 16'h000C);
    chk("add_dr", 16'(dr), 16'd1);

    // AND R1,R2,#-1
    drive(16'h52BF, 6'b010000, 16'hA5A5, 16'h1234, 16'h3001, 4'b0, 16'h0);
    m_cntrl_in = 1'b0; w_cntrl_in = 2'b01;
    cycle();
    chk("and_imm_aluout", aluout, 16'hA5A5);

    // NOT R4,R1
    drive(16'h987F, 6'b100000, 16'h00FF, 16'h0000, 16'h3002, 4'b0, 16'h0);
    cycle();
    chk("not_aluout", aluout, 16'hFF00);

    // BRnzp #-1 from npc 0 wraps to 0xFFFF
    drive(16'h0FFF, 6'b000110, 16'h4444, 16'h5555, 16'h0000, 4'b0, 16'h0);
    cycle();
    chk("br_pcout", pcout, 16'hFFFF);
    chk("br_nzp", 16'(NZP), 16'd7);

    // Produce 0x1111, then ADD #1 with both bypasses on operand 1
    drive(16'h1283, 6'b000001, 16'h1000, 16'h0111, 16'h3003, 4'b0, 16'h0);
    cycle();
    chk("byp_setup", aluout, 16'h1111);
    drive(16'h1061, 6'b000000, 16'h0BAD, 16'h0000, 16'h3004, 4'b1100, 16'h2222);
    cycle();
    chk("byp_alu_wins", aluout, 16'h1112);
    drive(16'h1061, 6'b000000, 16'h0BAD, 16'h0000, 16'h3005, 4'b0100, 16'h2222);
    cycle();
    chk("byp_mem", aluout, 16'h2223);

    // Stall: outputs hold, source addresses track the new IR
    enable_execute = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 16'($urandom));
      m_cntrl_in = 1'($urandom); w_cntrl_in = 2'($urandom);
      #1;
      chk_src();
      cycle();
      chk("stall_hold", aluout, 16'h2223);
    end
    enable_execute = 1'b1;
    drive(16'h3E05, 6'b001100, 16'h0010, 16'hBEEF, 16'h3006, 4'b0, 16'h0);
    #1;
    chk("st_sr2", 16'(sr2), 16'd7);
    cycle();
    chk("resume_mdata", M_Data, 16'hBEEF);

    // Asynchronous reset mid-stream
    drive(16'h1283, 6'b000001, 16'h0001, 16'h0002, 16'h3007, 4'b0, 16'h0);
    @(posedge clock);
    model_clock();
    #2 reset = 1'b1;
    #1;
    model_zero();
    chk_regs();
    cycle();
    #2 reset = 1'b0;
    #1;
    cycle();
    chk("post_reset_load", aluout, 16'h0003);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(16'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            4'($urandom), 16'($urandom));
      m_cntrl_in = 1'($urandom); w_cntrl_in = 2'($urandom);
      enable_execute = ($urandom_range(0, 4) != 0);
      #1;
      chk_src();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
